// File: rtl/dtfm_pkg.sv
// dtfm_pkg: shared writer state and default geometry for the DTFM group buffer
package dtfm_pkg;
  typedef enum logic [1:0] {HUNT, SHIFT, DROP} wr_state_t;
  localparam int DTFM_WORD_W = 12;
  localparam int DTFM_GROUP_LEN = 1024;
  localparam int DTFM_NBANKS = 2;
endpackage

// File: rtl/dtfm_sdp_ram.sv
// dtfm_sdp_ram: simple dual-port word RAM with registered read on rden
module dtfm_sdp_ram #(
  parameter int WORD_W = 12,
  parameter int DEPTH = 2048,
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rden,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (rden) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dtfm_group_buffer.sv
// dtfm_group_buffer: serial telemetry capture into an N-bank ring of word groups
module dtfm_group_buffer
  import dtfm_pkg::*;
#(
  parameter int WORD_W = DTFM_WORD_W,
  parameter int GROUP_LEN = DTFM_GROUP_LEN,
  parameter int NBANKS = DTFM_NBANKS,
  parameter int ADDR_W = $clog2(GROUP_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dCLK,
  input  logic              dFM,
  input  logic              dDAT,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  input  logic              iRdDone,
  output logic [WORD_W-1:0] oData,
  output logic              oGrpReady,
  output logic              oOverflow,
  output logic              oResync
);
  localparam int BW = $clog2(NBANKS);
  localparam int FW = $clog2(NBANKS + 1);
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NBANKS - 1);
  localparam logic [FW-1:0] FULL = FW'(NBANKS);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GROUP_LEN - 1);
  wr_state_t state, state_n;
  logic [1:0] clk_s, fm_s, dat_s;
  logic clk_q, stb, fm, dat, rel;
  logic start, ovf, rsy, shift, word_end, grp_end;
  logic [WORD_W-1:0] shifter, wd;
  logic [CW-1:0] bitcnt;
  logic [ADDR_W-1:0] waddr;
  logic [BW-1:0] wbank, rbank;
  logic [FW-1:0] fill;
  logic [BW+ADDR_W-1:0] wa;
  logic we, wlast;
  assign stb = clk_s[1] & ~clk_q;
  assign fm = fm_s[1];
  assign dat = dat_s[1];
  assign rel = iRdDone & (fill != '0);
  assign oGrpReady = fill != '0;
  always_comb begin
    start = stb & fm & (state != SHIFT) & (fill != FULL);
    ovf = stb & fm & (state != SHIFT) & (fill == FULL);
    rsy = stb & fm & (state == SHIFT);
    shift = stb & ~fm & (state == SHIFT);
    word_end = shift & (bitcnt == LAST_BIT);
    grp_end = word_end & (waddr == LAST_ADDR);
  end
  always_comb begin
    state_n = (start | rsy) ? SHIFT : ovf ? DROP : grp_end ? HUNT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      clk_s <= '0;
      fm_s <= '0;
      dat_s <= '0;
      clk_q <= 1'b0;
      shifter <= '0;
      bitcnt <= '0;
      waddr <= '0;
      wbank <= '0;
      rbank <= '0;
      fill <= '0;
      we <= 1'b0;
      wlast <= 1'b0;
      wa <= '0;
      wd <= '0;
      oOverflow <= 1'b0;
      oResync <= 1'b0;
    end else begin
      state <= state_n;
      clk_s <= {clk_s[0], dCLK};
      fm_s <= {fm_s[0], dFM};
      dat_s <= {dat_s[0], dDAT};
      clk_q <= clk_s[1];
      shifter <= (start | rsy) ? WORD_W'(dat) : shift ? {shifter[WORD_W-2:0], dat} : shifter;
      bitcnt <= (start | rsy) ? CW'(1) : word_end ? '0 : shift ? bitcnt + 1'b1 : bitcnt;
      waddr <= (start | rsy | grp_end) ? '0 : word_end ? waddr + 1'b1 : waddr;
      we <= word_end;
      wlast <= grp_end;
      wa <= {wbank, waddr};
      wd <= {shifter[WORD_W-2:0], dat};
      wbank <= wlast ? ((wbank == LAST_BANK) ? '0 : wbank + 1'b1) : wbank;
      rbank <= rel ? ((rbank == LAST_BANK) ? '0 : rbank + 1'b1) : rbank;
      fill <= fill + FW'(wlast) - FW'(rel);
      oOverflow <= ovf;
      oResync <= rsy;
    end
  end
  dtfm_sdp_ram #(
    .WORD_W(WORD_W),
    .DEPTH(NBANKS * GROUP_LEN),
    .AW(BW + ADDR_W)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(wa),
    .wdata(wd),
    .rden(iRdEn),
    .raddr({rbank, iRdAddr}),
    .rdata(oData)
  );
endmodule

// File: doc/dtfm_group_buffer.md
# dtfm_group_buffer

Parametrised successor to the two-bank group buffer in the DTFM top level. It captures the serial telemetry stream (bit clock, frame marker, data), assembles WORD_W-bit words and writes whole groups into an N-bank ring of group buffers. It hands completed groups to the frame former through a ready/done handshake, so the frame former no longer drives bank selection itself. It sits between the dCLK/dFM/dDAT pins and the frame former, in the same clock domain as the frame former.

## Interface
- WORD_W, 12, bits per word
- GROUP_LEN, 1024, words per group (bank depth)
- NBANKS, 2, number of banks in the ring (2..8)
- ADDR_W, $clog2(GROUP_LEN), read address width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dCLK  in  1  serial bit clock, asynchronous; data valid on its rising edge
- dFM  in  1  frame marker, high during the first bit of a group
- dDAT  in  1  serial data, MSB first
- iRdEn  in  1  read strobe
- iRdAddr  in  ADDR_W  word address within the current read bank
- iRdDone  in  1  one-cycle pulse: reader releases the current read bank
- oData  out  WORD_W  read data
- oGrpReady  out  1  at least one full bank is available to read
- oOverflow  out  1  one-cycle pulse: incoming group dropped, all banks full
- oResync  out  1  one-cycle pulse: dFM arrived mid-group, partial group discarded

## Operation
- Input path: dCLK, dFM and dDAT each pass through a 2-flop synchroniser. Rising-edge detect on synced dCLK gives bit_stb. dFM and dDAT are sampled on bit_stb.
- Writer FSM states: HUNT, SHIFT, DROP.
- HUNT:
  - bit_stb with dFM=1 and fill<NBANKS: load bit into shifter, bitcnt=1, waddr=0, go to SHIFT.
  - bit_stb with dFM=1 and fill==NBANKS: pulse oOverflow, go to DROP.
  - Bits with dFM=0 are ignored.
- SHIFT: shift in each bit. When bitcnt reaches WORD_W, write the word to {wbank, waddr}, then waddr++ and bitcnt=0.
  - The write of word GROUP_LEN-1 completes the group: fill++, wbank advances modulo NBANKS, FSM goes to HUNT.
- SHIFT with dFM=1 on any bit other than the first: pulse oResync, discard the partial group, restart the same bank at waddr=0 with this bit as bit 0. Fill is unchanged.
- DROP: ignore bits until bit_stb with dFM=1, then re-evaluate exactly as in HUNT on that same bit.
- Reader: rbank points to the oldest full bank. oGrpReady = (fill!=0).
  - iRdEn reads {rbank, iRdAddr}.
  - iRdDone with fill!=0: rbank advances modulo NBANKS, fill--.
  - iRdDone with fill==0: ignored.
- Group completion and iRdDone in the same cycle: fill unchanged, both pointers advance.
- Reads of the write bank while fill==0 are permitted and return undefined data; the bench does not check them.

## Timing
- Reset values: oData=0, oGrpReady=0, oOverflow=0, oResync=0, state=HUNT, fill=0, wbank=0, rbank=0, waddr=0, bitcnt=0. Synchroniser flops are cleared. RAM contents are not reset.
- rst asserted mid-group: the partial group and all full banks are discarded. The first group after reset must start with dFM.
- bit_stb occurs 3 clk after the dCLK rising edge reaches the pin. dCLK high and low phases must each be at least 2 clk.
- The last bit of a word is written to RAM on the clk after its bit_stb.
- oGrpReady rises on the clk after the final RAM write of a group.
- oGrpReady falls on the clk after iRdDone when fill goes 1→0.
- Read latency: oData is valid 1 clk after iRdEn. oData holds its value when iRdEn=0.
- oOverflow and oResync are asserted on the clk after the offending bit_stb.
- fill width is $clog2(NBANKS+1). waddr wraps only through group completion and never exceeds GROUP_LEN-1.

## Structure
- Package dtfm_pkg holds the writer state enum (HUNT, SHIFT, DROP) and the default WORD_W/GROUP_LEN/NBANKS constants shared with the frame former.
- One sub-module: dtfm_sdp_ram. It is a simple dual-port RAM of NBANKS*GROUP_LEN words of WORD_W bits, address {bank, addr}, with a registered read on rden.
- Synchroniser, edge detector, writer FSM and bank ring stay in the top module.

## Test plan
All scenarios use WORD_W=12, GROUP_LEN=4, NBANKS=2.
- Happy path: reset, then send one group (dFM on the first bit) with words 0xABC, 0x123, 0xFFF, 0x001. Then oGrpReady=1; reads of addr 0..3 return those words, 1 clk after iRdEn; iRdDone causes oGrpReady=0.
- Overflow: send 3 groups with no iRdDone. Group 3 start gives one oOverflow pulse and fill stays 2. After one iRdDone, group 4 is accepted into bank 0.
- Resync: send 20 bits of a group, then dFM=1 again. Gives one oResync pulse. The next 48 bits form the group, and the first word read equals the first word after the resync.
- Simultaneous events: fill=1 and reader holds bank 0. The second group completes in the same clk as iRdDone. Then fill=1, rbank=1, oGrpReady stays 1, and bank 1 data is correct.
- Reset mid-group: assert rst after 30 bits. All outputs return to reset values and oGrpReady=0. Bits without dFM are ignored until the next dFM.
- Stray release: iRdDone with fill=0 leaves fill, rbank and oGrpReady unchanged.
